// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam logic [7:0] ARB_TIMEOUT = 8'd255;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data-stage requests onto one shared registered memory
// port, with round-robin tie-breaking and a per-transaction watchdog.
module mem_arbiter
  import arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IReady,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  input  logic [3:0]  DBe,
  output logic [31:0] DRdata,
  output logic        DReady,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        StallF,
  output logic        StallM,
  output logic        ErrTimeout
);

  state_t     state, state_next;
  grant_t     last_grant, grant;
  logic [7:0] watchdog;
  logic       i_elig, d_elig, grant_valid, acked, done;

  // A requester is not eligible while its own Ready is high, so a held
  // request is not granted a second time for the same access.
  assign i_elig = IReq & ~IReady;
  assign d_elig = DReq & ~DReady;
  assign StallF = IReq & ~IReady;
  assign StallM = DReq & ~DReady;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:         if (grant_valid) state_next = (grant == GRANT_I) ? IBUSY : DBUSY;
      IBUSY, DBUSY: if (done) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before any branch, otherwise an
  // unassigned path would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant       = GRANT_I;
    acked       = 1'b0;
    done        = 1'b0;
    if (state == IDLE) begin
      grant_valid = i_elig | d_elig;
      if (i_elig && d_elig) grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
      else if (d_elig)      grant = GRANT_D;
    end else begin
      acked = mem_ack;
      done  = mem_ack | (watchdog == ARB_TIMEOUT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      IReady     <= 1'b0;
      DReady     <= 1'b0;
      IRdata     <= '0;
      DRdata     <= '0;
      watchdog   <= '0;
      ErrTimeout <= 1'b0;
      last_grant <= GRANT_I;
    end else begin
      IReady <= 1'b0;
      DReady <= 1'b0;
      if (grant_valid) begin
        mem_req    <= 1'b1;
        last_grant <= grant;
        watchdog   <= '0;
        if (grant == GRANT_I) begin
          mem_we    <= 1'b0;
          mem_addr  <= IAddr;
          mem_wdata <= '0;
          mem_be    <= 4'hF;
        end else begin
          mem_we    <= DWe;
          mem_addr  <= DAddr;
          mem_wdata <= DWdata;
          mem_be    <= DBe;
        end
      end else if (done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        // Timed-out completions and stores return zero data.
        if (state == IBUSY) begin
          IReady <= 1'b1;
          IRdata <= acked ? mem_rdata : '0;
        end else begin
          DReady <= 1'b1;
          DRdata <= (acked && !mem_we) ? mem_rdata : '0;
        end
        if (!acked) ErrTimeout <= 1'b1;
      end else if (state != IDLE) begin
        watchdog <= watchdog + 8'd1;
      end
    end
  end

endmodule
